// File: rtl/bcd16_to_bin14.sv
// Sequential 4-digit BCD to 14-bit binary converter using reverse double-dabble.
// Optional invalid-digit check: define BCD16_TO_BIN14_DIGIT_CHECK_EN.
module bcd16_to_bin14 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bcd,
  output logic        busy,
  output logic        done,
  output logic [13:0] bin,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

  state_t      state, state_nxt;
  logic [29:0] sr, sr_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        load_res;
  logic [13:0] bin_nxt;

  // One iteration: shift right, then pull 3 out of every BCD field that reached 8.
  function automatic logic [29:0] conv_step(input logic [29:0] v);
    logic [29:0] s;
    s = {1'b0, v[29:1]};
    for (int i = 0; i < 4; i++) begin
      if (s[14+4*i +: 4] >= 4'd8)
        s[14+4*i +: 4] = s[14+4*i +: 4] - 4'd3;
    end
    return s;
  endfunction

`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
  logic err_nxt;
  logic bad_in;

  function automatic logic digit_bad(input logic [15:0] v);
    logic b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9)
        b = 1'b1;
    end
    return b;
  endfunction

  assign bad_in = digit_bad(bcd);
`endif

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    load_res  = 1'b0;
    bin_nxt   = bin;
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
    err_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          sr_nxt    = {bcd, 14'b0};
          cnt_nxt   = 4'd0;
          state_nxt = CONV;
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
          // Invalid words bypass conversion and report straight away.
          if (bad_in) begin
            state_nxt = FINISH;
            load_res  = 1'b1;
            bin_nxt   = 14'd0;
            err_nxt   = 1'b1;
          end
`endif
        end
      end
      CONV: begin
        sr_nxt  = conv_step(sr);
        cnt_nxt = cnt + 4'd1;
        if (cnt == 4'd13) begin
          state_nxt = FINISH;
          load_res  = 1'b1;
          bin_nxt   = sr_nxt[13:0];
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      bin   <= '0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      if (load_res)
        bin <= bin_nxt;
    end
  end

`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err <= 1'b0;
    else if (load_res)
      err <= err_nxt;
  end
`else
  assign err = 1'b0;
`endif

  assign busy = (state == CONV);
  assign done = (state == FINISH);

endmodule

// File: tb/tb_bcd16_to_bin14.sv
// Directed bench for bcd16_to_bin14: latency, values, start/bcd isolation, back-to-back, reset abort.
module tb_bcd16_to_bin14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [15:0] bcd = 16'h0000;
  logic        busy, done, err;
  logic [13:0] bin;

  int passed = 0;
  int total  = 0;

  bcd16_to_bin14 dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bcd  (bcd),
    .busy (busy),
    .done (done),
    .bin  (bin),
    .err  (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one request at a negedge, then watch until done or a 40-cycle bound.
  // dat = cycle index (1 = first cycle after capture edge) of done, 0 if none.
  task automatic run_conv(input logic [15:0] v, output int nbusy, output int dat);
    nbusy = 0;
    dat   = 0;
    @(negedge clk);
    bcd   = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) nbusy++;
      if (done) begin
        dat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int nb, dat, ndone, first_d, last_d;

    // Reset
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bin",  32'(bin),  32'd0);
    check("rst_err",  32'(err),  32'd0);
    rst_n = 1'b1;

    // Zero input, latency and busy width
    run_conv(16'h0000, nb, dat);
    check("zero_done_at", 32'(dat), 32'd15);
    check("zero_busy_cnt", 32'(nb), 32'd14);
    check("zero_bin", 32'(bin), 32'd0);
    check("zero_err", 32'(err), 32'd0);
    @(negedge clk);
    check("zero_done_pulse", 32'(done), 32'd0);

    // Maximum value and a power-of-two boundary
    run_conv(16'h9999, nb, dat);
    check("9999_done_at", 32'(dat), 32'd15);
    check("9999_bin", 32'(bin), 32'h270F);
    repeat (5) @(negedge clk);
    check("9999_bin_hold", 32'(bin), 32'h270F);
    run_conv(16'h4095, nb, dat);
    check("4095_bin", 32'(bin), 32'h0FFF);
    run_conv(16'h8000, nb, dat);
    check("8000_bin", 32'(bin), 32'd8000);
    run_conv(16'h0010, nb, dat);
    check("0010_bin", 32'(bin), 32'd10);

    // bcd change and start pulse during CONV are ignored
    @(negedge clk);
    bcd   = 16'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    dat   = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) bcd = 16'h5678;
      start = (k == 5);
      if (done) begin
        ndone++;
        if (dat == 0) begin
          dat = k;
          check("isol_bin", 32'(bin), 32'd1234);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("isol_done_at", 32'(dat), 32'd15);
    check("isol_single_done", 32'(ndone), 32'd1);

    // start held high: one conversion every 16 cycles
    @(negedge clk);
    bcd   = 16'h0001;
    start = 1'b1;
    ndone = 0;
    first_d = 0;
    last_d  = 0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (first_d == 0) first_d = k;
        last_d = k;
        check("held_bin", 32'(bin), 32'd1);
      end
    end
    start = 1'b0;
    check("held_count", 32'(ndone), 32'd4);
    check("held_first", 32'(first_d), 32'd15);
    check("held_span", 32'(last_d - first_d), 32'd48);

    // Reset in the middle of a conversion
    repeat (2) @(negedge clk);
    bcd   = 16'h8765;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bin",  32'(bin),  32'd0);
    check("abort_err",  32'(err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    run_conv(16'h0042, nb, dat);
    check("post_abort_done_at", 32'(dat), 32'd15);
    check("post_abort_bin", 32'(bin), 32'd42);

    // Invalid digit
    run_conv(16'h12A4, nb, dat);
`ifdef BCD16_TO_BIN14_DIGIT_CHECK_EN
    check("bad_done_at", 32'(dat), 32'd1);
    check("bad_busy_cnt", 32'(nb), 32'd0);
    check("bad_err", 32'(err), 32'd1);
    check("bad_bin", 32'(bin), 32'd0);
`else
    check("bad_done_at", 32'(dat), 32'd15);
    check("bad_busy_cnt", 32'(nb), 32'd14);
    check("bad_err", 32'(err), 32'd0);
`endif
    run_conv(16'h0007, nb, dat);
    check("valid_after_bad_err", 32'(err), 32'd0);
    check("valid_after_bad_bin", 32'(bin), 32'd7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
